// File: rtl/tile_renderer.sv
// -----------------------------------------------------------------------------
// tile_renderer
//
// Purpose:
//   Two-stage pixel pipeline that draws a 4x4 game board of tiles on a VGA
//   raster. Stage 1 decodes the beam position into a tile column/row and a
//   local coordinate inside the tile. It drives the glyph renderer from these
//   values. Stage 2 merges the returned glyph pixel with the tile colour and
//   registers the final rgb.
//   The board is snapshotted once per frame, so a frame never tears mid-way.
//   A newly spawned tile blinks white for 31 frames.
//
// Ports:
//   clk, rst_n               pixel clock, asynchronous active-low reset
//   hpos, vpos               current beam coordinates (10 bit)
//   display_on, hsync_in,
//   vsync_in                 timing from the VGA generator
//   board                    16 cells x 4-bit exponent index, cell = row*4+col
//   spawn_valid, spawn_cell  one-cycle pulse marking a newly spawned tile
//   glyph_index/x/y          request to the glyph renderer (stage 1)
//   glyph_pixel              combinational glyph bit for that request
//   rgb                      {R[1:0],G[1:0],B[1:0]}, 2 cycles after hpos/vpos
//   hsync, vsync             sync inputs delayed by 2 cycles
// -----------------------------------------------------------------------------
module tile_renderer #(
  parameter int X0 = 168,
  parameter int Y0 = 88
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  hpos,
  input  logic [9:0]  vpos,
  input  logic        display_on,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [63:0] board,
  input  logic        spawn_valid,
  input  logic [3:0]  spawn_cell,
  output logic [3:0]  glyph_index,
  output logic [5:0]  glyph_x,
  output logic [5:0]  glyph_y,
  input  logic        glyph_pixel,
  output logic [5:0]  rgb,
  output logic        hsync,
  output logic        vsync
);

  localparam logic [9:0] X_ORG = 10'(X0);
  localparam logic [9:0] Y_ORG = 10'(Y0);

  // Decodes one axis into {in_board, in_tile, index[1:0], local[5:0]}.
  // The tile index comes from comparing against the pitch boundaries, so no
  // divider is needed. A position left of or above the origin wraps to a large
  // unsigned offset and falls outside the board.
  function automatic logic [9:0] axis_decode(input logic [9:0] pos,
                                             input logic [9:0] org);
    logic [9:0] d;
    logic [9:0] base;
    logic [9:0] off;
    logic [1:0] idx;
    logic [5:0] loc;
    d = pos - org;
    if (d < 10'd72) begin
      idx  = 2'd0;
      base = 10'd0;
    end else if (d < 10'd144) begin
      idx  = 2'd1;
      base = 10'd72;
    end else if (d < 10'd216) begin
      idx  = 2'd2;
      base = 10'd144;
    end else begin
      idx  = 2'd3;
      base = 10'd216;
    end
    off = d - base;
    // local coordinate = off - 8, kept modulo 64 (valid when inside a tile)
    loc = off[5:0] - 6'd8;
    return {(pos >= org) && (d <= 10'd295),
            (off >= 10'd8) && (off <= 10'd71),
            idx, loc};
  endfunction

  logic [9:0] h_dec;
  logic [9:0] v_dec;
  logic       frame_strobe;

  assign h_dec        = axis_decode(hpos, X_ORG);
  assign v_dec        = axis_decode(vpos, Y_ORG);
  assign frame_strobe = (vpos == 10'd480) && (hpos == 10'd0);

  // ---------------------------------------------------------------- stage 1
  logic [1:0] s1_col;
  logic [1:0] s1_row;
  logic [5:0] s1_lx;
  logic [5:0] s1_ly;
  logic       s1_in_tile;
  logic       s1_in_board;
  logic       s1_de;
  logic       s1_hs;
  logic       s1_vs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_col      <= 2'd0;
      s1_row      <= 2'd0;
      s1_lx       <= 6'd0;
      s1_ly       <= 6'd0;
      s1_in_tile  <= 1'b0;
      s1_in_board <= 1'b0;
      s1_de       <= 1'b0;
      s1_hs       <= 1'b0;
      s1_vs       <= 1'b0;
    end else begin
      s1_col      <= h_dec[7:6];
      s1_row      <= v_dec[7:6];
      s1_lx       <= h_dec[5:0];
      s1_ly       <= v_dec[5:0];
      s1_in_board <= h_dec[9] & v_dec[9];
      s1_in_tile  <= h_dec[9] & v_dec[9] & h_dec[8] & v_dec[8];
      s1_de       <= display_on;
      s1_hs       <= hsync_in;
      s1_vs       <= vsync_in;
    end
  end

  // ------------------------------------------------- snapshot and highlight
  logic [63:0] board_snap;
  logic [3:0]  hl_cell;
  logic [4:0]  hl_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      board_snap <= 64'd0;
    end else if (frame_strobe) begin
      board_snap <= board;
    end
  end

  // A spawn has priority over the frame decrement. It also restarts a running
  // highlight on the new cell.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hl_cell <= 4'd0;
      hl_cnt  <= 5'd0;
    end else if (spawn_valid) begin
      hl_cell <= spawn_cell;
      hl_cnt  <= 5'd31;
    end else if (frame_strobe && (hl_cnt != 5'd0)) begin
      hl_cnt <= hl_cnt - 5'd1;
    end
  end

  // ------------------------------------------------------ glyph interface
  logic [3:0] tile_cell;
  logic [3:0] snap_val;

  assign tile_cell   = {s1_row, s1_col};
  assign snap_val    = board_snap[{tile_cell, 2'b00} +: 4];
  assign glyph_index = s1_in_tile ? snap_val : 4'd0;
  assign glyph_x     = s1_lx;
  assign glyph_y     = s1_ly;

  // ---------------------------------------------------------------- stage 2
  logic       hl_on;
  logic [5:0] tile_rgb;
  logic [5:0] rgb_next;

  // Blink: lit on frames where bit 2 of the countdown is set (8-frame period).
  assign hl_on = (hl_cnt != 5'd0) && hl_cnt[2];

  always_comb begin
    tile_rgb = 6'b110011;
    if (glyph_index <= 4'd2) begin
      tile_rgb = 6'b111110;
    end else if (glyph_index <= 4'd4) begin
      tile_rgb = 6'b111000;
    end else if (glyph_index <= 4'd6) begin
      tile_rgb = 6'b110000;
    end else if (glyph_index <= 4'd11) begin
      tile_rgb = 6'b111100;
    end
  end

  always_comb begin
    rgb_next = 6'b000000;
    if (!s1_de || !s1_in_board) begin
      rgb_next = 6'b000000;
    end else if (!s1_in_tile) begin
      rgb_next = 6'b010101;
    end else if (hl_on && (tile_cell == hl_cell)) begin
      rgb_next = glyph_pixel ? 6'b000000 : 6'b111111;
    end else if (glyph_index == 4'd0) begin
      rgb_next = 6'b101010;
    end else if (glyph_pixel) begin
      rgb_next = (glyph_index <= 4'd2) ? 6'b000000 : 6'b111111;
    end else begin
      rgb_next = tile_rgb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb   <= 6'b000000;
      hsync <= 1'b0;
      vsync <= 1'b0;
    end else begin
      rgb   <= rgb_next;
      hsync <= s1_hs;
      vsync <= s1_vs;
    end
  end

endmodule

// File: doc/tile_renderer.md
TILE_RENDERER -- requirements
Module: tile_renderer

Interface
REQ-001 SHALL have parameter X0, default 168, giving the board left edge in pixels.
REQ-002 SHALL have parameter Y0, default 88, giving the board top edge in pixels.
REQ-003 SHALL have port clk, input, 1 bit, the pixel clock; it is the only clock.
REQ-004 SHALL have port rst_n, input, 1 bit, the asynchronous active-low reset.
REQ-005 SHALL have ports hpos and vpos, input, 10 bits each, the current VGA beam coordinates.
REQ-006 SHALL have ports display_on, hsync_in and vsync_in, input, 1 bit each, the timing from the VGA generator.
REQ-007 SHALL have port board, input, 64 bits; cell i = board[4i+3:4i], i = row*4+col, value = tile exponent index (0 = empty).
REQ-008 SHALL have ports spawn_valid (1 bit) and spawn_cell (4 bits), inputs, a one-cycle pulse marking a newly spawned tile.
REQ-009 SHALL have ports glyph_index (4 bits), glyph_x (6 bits) and glyph_y (6 bits), outputs, driving the number-glyph renderer.
REQ-010 SHALL have port glyph_pixel, input, 1 bit, the combinational glyph pixel returned for the current glyph_index/x/y.
REQ-011 SHALL have port rgb, output, 6 bits, {R[1:0],G[1:0],B[1:0]}.
REQ-012 SHALL have ports hsync and vsync, outputs, 1 bit each, the delayed sync signals.

Function
REQ-013 Geometry SHALL be: tile pitch 72; for c,r in 0..3, tile (c,r) covers x = X0+72c+8 .. X0+72c+71 and y = Y0+72r+8 .. Y0+72r+71; board area = X0..X0+295 x Y0..Y0+295.
REQ-014 Stage 1 SHALL register, every cycle, from hpos/vpos: col, row, local x (hpos-tile_left, 0..63), local y, in_tile, in_board, display_on, hsync_in, vsync_in.
REQ-015 The block SHALL compute col/row by comparison against the four pitch boundaries; no divider.
REQ-016 glyph_x/glyph_y SHALL equal the stage-1 local x/y.
REQ-017 glyph_index SHALL equal snapshot cell (row*4+col) when stage-1 in_tile=1, and 0 otherwise.
REQ-018 glyph_index, glyph_x and glyph_y SHALL be valid one cycle after hpos/vpos are sampled.
REQ-019 Stage 2 SHALL register rgb from the stage-1 data plus glyph_pixel; rgb SHALL appear exactly 2 cycles after the corresponding hpos/vpos.
REQ-020 hsync/vsync SHALL be delayed by the same 2 cycles.
REQ-021 Colour priority: display_on=0 -> 000000; outside board -> 000000; in board, not in tile -> 010101; tile index 0 -> 101010.
REQ-022 Tile colour by index SHALL be: 1-2 -> 111110; 3-4 -> 111000; 5-6 -> 110000; 7-11 -> 111100; 12-15 -> 110011.
REQ-023 When glyph_pixel=1, the glyph colour SHALL be 000000 for index 1-2 and 111111 otherwise.
REQ-024 Snapshot: on a cycle with vpos==480 and hpos==0 (frame strobe), board_snap SHALL load board; at all other times it SHALL hold, so there is no mid-frame tearing.
REQ-025 Highlight: spawn_valid SHALL load hl_cell<=spawn_cell and hl_cnt<=31.
REQ-026 Each frame strobe SHALL decrement hl_cnt if it is nonzero; it SHALL saturate at 0.
REQ-027 If spawn_valid and the frame strobe coincide, spawn SHALL win: hl_cnt=31, no decrement.
REQ-028 A spawn during an active highlight SHALL restart it on the new cell.
REQ-029 While hl_cnt!=0 and hl_cnt[2]=1, tile hl_cell SHALL render with background 111111 and glyph 000000, overriding REQ-022/023 (blink period 8 frames).
REQ-030 All arithmetic SHALL be unsigned 10-bit; hpos/vpos beyond 639/479 SHALL be handled like any other value (blanked via display_on).

Reset
REQ-031 rst_n=0 SHALL asynchronously clear: all stage registers, board_snap=0, hl_cnt=0, hl_cell=0, rgb=000000, hsync=0, vsync=0, glyph_index=0, glyph_x=0, glyph_y=0.
REQ-032 Deasserting reset mid-frame SHALL produce correct rgb from the 2nd cycle after release, with the board empty until the next frame strobe.

Verification
REQ-033 board=0 latched at strobe; hpos=X0+8, vpos=Y0+8, display_on=1 -> 2 cycles later rgb=101010, glyph_index=0 at +1.
REQ-034 board cell5=11, strobe, then hpos=X0+72+8+10, vpos=Y0+72+8+20 -> at +1 glyph_index=11, x=10, y=20; glyph_pixel=1 -> rgb=111111 at +2; glyph_pixel=0 -> 111100.
REQ-035 Change board mid-frame (no strobe) -> glyph_index unchanged until the next strobe, then updated.
REQ-036 Gap pixel hpos=X0+72 -> rgb=010101; hpos=X0-1 -> 000000; display_on=0 anywhere -> 000000; hsync/vsync equal the inputs delayed 2 cycles.
REQ-037 spawn_valid cell 0 coincident with strobe -> hl_cnt=31; after 31 strobes 0; blink colours 111111 on frames with hl_cnt[2]=1; a second spawn at hl_cnt=10 reloads 31.
REQ-038 Assert rst_n mid-line -> all outputs 0 immediately without a clock edge; release -> snapshot empty until the next strobe.
